// File: rtl/bus_slave_ctrl_mc_pkg.sv
// Shared helpers for the multi-channel bus slave controller: pointer sizing
// and the packed {addr,data} entry width used by the write-channel FIFOs.
package slave_ctrl_pkg;

    localparam int DROP_CNT_W = 16;

    // Minimum bit count to index 'value' entries (never less than 1).
    function automatic int clog2_f(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // {addr,data} packed width, padded up to an even bit count.
    function automatic int entry_w(input int addr_len, input int data_len);
        int w;
        w = addr_len + data_len;
        if ((w % 2) != 0) begin
            w = w + 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_slave_ctrl_mc_if.sv
// Shared TABLA data bus as seen by one slave: outgoing word register plus
// the incoming word channel.
interface bus_slave_ctrl_mc_if #(
    parameter int BUS_ADDR_LEN = 3,
    parameter int DATA_LEN     = 16
);
    logic                    valid_to_bus;
    logic [BUS_ADDR_LEN-1:0] addr_to_bus;
    logic [DATA_LEN-1:0]     data_to_bus;
    logic [BUS_ADDR_LEN-1:0] bus_src_out;
    logic                    bus_grant;
    logic                    bus_valid;
    logic [BUS_ADDR_LEN-1:0] bus_src;
    logic [DATA_LEN-1:0]     bus_data;

    modport slave (
        output valid_to_bus, addr_to_bus, data_to_bus, bus_src_out,
        input  bus_grant, bus_valid, bus_src, bus_data
    );

    modport master (
        input  valid_to_bus, addr_to_bus, data_to_bus, bus_src_out,
        output bus_grant, bus_valid, bus_src, bus_data
    );
endinterface

// File: rtl/bus_slave_ctrl_mc_bus_fifo_sync.sv
// Synchronous show-ahead FIFO with registered full/empty; a push into a full
// FIFO is accepted when the same cycle pops.
module bus_fifo_sync
    import slave_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = clog2_f(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;

    // Qualify requests and compute the occupancy after this cycle.
    always_comb begin
        pop_s  = pop & ~empty_r;
        push_s = push & (~full_r | pop_s);
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (push_s) wptr_r <= wptr_r + AW'(1);
            else        wptr_r <= wptr_r;
            if (pop_s)  rptr_r <= rptr_r + AW'(1);
            else        rptr_r <= rptr_r;
            count_r <= count_next_s;
            full_r  <= (count_next_s == DEPTH_C);
            empty_r <= (count_next_s == '0);
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wptr_r] <= din;
        else        mem_r[wptr_r] <= mem_r[wptr_r];
    end

    assign dout  = mem_r[rptr_r];
    assign full  = full_r;
    assign empty = empty_r;
endmodule

// File: rtl/bus_slave_ctrl_mc.sv
// Multi-channel bus slave: round-robin merge of write channels onto the bus
// register, per-source read buffers popped by the PE. Optional drop counter
// is enabled by defining SLV_OVERFLOW_CNT_EN.
module bus_slave_ctrl_mc
    import slave_ctrl_pkg::*;
#(
    parameter int BUS_ADDR_LEN  = 3,
    parameter int DATA_LEN      = 16,
    parameter int PE_ID         = 0,
    parameter int NUM_WR_CH     = 2,
    parameter int WR_FIFO_DEPTH = 8,
    parameter int NUM_SRC       = 8,
    parameter int RD_DEPTH      = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              stall,
    input  logic [NUM_WR_CH-1:0]              wr_valid,
    input  logic [NUM_WR_CH*BUS_ADDR_LEN-1:0] wr_addr,
    input  logic [NUM_WR_CH*DATA_LEN-1:0]     wr_data,
    output logic [NUM_WR_CH-1:0]              wr_full,
    bus_slave_ctrl_mc_if.slave                bus,
    input  logic                              src_rq,
    input  logic [BUS_ADDR_LEN-1:0]           src_addr,
    output logic                              src_valid,
    output logic [DATA_LEN-1:0]               src_data,
`ifdef SLV_OVERFLOW_CNT_EN
    output logic [DROP_CNT_W-1:0]             drop_count,
`endif
    output logic [NUM_SRC-1:0]                rd_buffer_full
);
    localparam int EW = entry_w(BUS_ADDR_LEN, DATA_LEN);
    localparam int PW = clog2_f(NUM_WR_CH);

    logic [NUM_WR_CH-1:0]    cand_valid_s;
    logic [EW-1:0]           cand_entry_s [NUM_WR_CH];
    logic [EW-1:0]           sel_entry_s;
    logic                    sel_found_s;
    logic [PW-1:0]           sel_idx_s;
    logic                    load_s;
    logic [PW-1:0]           ptr_r;
    logic                    out_valid_r;
    logic [BUS_ADDR_LEN-1:0] out_addr_r;
    logic [DATA_LEN-1:0]     out_data_r;

    // A channel whose FIFO is empty offers its incoming word directly, so a
    // push into an idle output register reaches the bus one cycle later.
    for (genvar c = 0; c < NUM_WR_CH; c++) begin : g_wr
        logic          empty_s;
        logic          sel_s;
        logic          push_s;
        logic          pop_s;
        logic [EW-1:0] din_s;
        logic [EW-1:0] dout_s;

        assign din_s  = EW'({wr_addr[c*BUS_ADDR_LEN +: BUS_ADDR_LEN], wr_data[c*DATA_LEN +: DATA_LEN]});
        assign sel_s  = sel_found_s & (sel_idx_s == PW'(c));
        assign push_s = wr_valid[c] & ~wr_full[c] & ~(sel_s & empty_s);
        assign pop_s  = sel_s & ~empty_s;
        assign cand_valid_s[c] = ~empty_s | (wr_valid[c] & ~wr_full[c]);
        assign cand_entry_s[c] = empty_s ? din_s : dout_s;

        bus_fifo_sync #(.WIDTH(EW), .DEPTH(WR_FIFO_DEPTH)) u_wr_fifo (
            .clk(clk), .rstn(rstn), .push(push_s), .pop(pop_s),
            .din(din_s), .dout(dout_s), .full(wr_full[c]), .empty(empty_s)
        );
    end

    // Round-robin pick: first offering channel at or after the pointer.
    always_comb begin
        load_s      = ~out_valid_r | bus.bus_grant;
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = 0; i < NUM_WR_CH; i++) begin
            if (load_s && !sel_found_s && cand_valid_s[(int'(ptr_r) + i) % NUM_WR_CH]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = PW'((int'(ptr_r) + i) % NUM_WR_CH);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        sel_entry_s = cand_entry_s[sel_idx_s];
    end

    // Bus output register and arbiter pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r       <= '0;
            out_valid_r <= 1'b0;
            out_addr_r  <= '0;
            out_data_r  <= '0;
        end else if (sel_found_s) begin
            out_valid_r <= 1'b1;
            out_addr_r  <= sel_entry_s[DATA_LEN +: BUS_ADDR_LEN];
            out_data_r  <= sel_entry_s[DATA_LEN-1:0];
            ptr_r       <= (int'(sel_idx_s) == NUM_WR_CH - 1) ? '0 : sel_idx_s + PW'(1);
        end else if (load_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.valid_to_bus = out_valid_r;
    assign bus.addr_to_bus  = out_addr_r;
    assign bus.data_to_bus  = out_data_r;
    assign bus.bus_src_out  = BUS_ADDR_LEN'(PE_ID);

    logic [NUM_SRC-1:0]  rd_empty_s;
    logic [NUM_SRC-1:0]  rd_pop_req_s;
    logic [DATA_LEN-1:0] rd_dout_s [NUM_SRC];
    logic                rd_hit_s;
    logic [DATA_LEN-1:0] rd_sel_data_s;
    logic                src_ok_s;
    logic                slot_blocked_s;
    logic                drop_s;
    logic                src_valid_r;
    logic [DATA_LEN-1:0] src_data_r;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_rd
        logic push_s;
        assign push_s          = bus.bus_valid & (bus.bus_src == BUS_ADDR_LEN'(s));
        assign rd_pop_req_s[s] = src_rq & ~stall & (src_addr == BUS_ADDR_LEN'(s));

        bus_fifo_sync #(.WIDTH(DATA_LEN), .DEPTH(RD_DEPTH)) u_rd_fifo (
            .clk(clk), .rstn(rstn), .push(push_s), .pop(rd_pop_req_s[s]),
            .din(bus.bus_data), .dout(rd_dout_s[s]),
            .full(rd_buffer_full[s]), .empty(rd_empty_s[s])
        );
    end

    // Pop-slot lookup and drop detection; a full slot still accepts when popped.
    always_comb begin
        rd_hit_s       = 1'b0;
        rd_sel_data_s  = '0;
        src_ok_s       = 1'b0;
        slot_blocked_s = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (src_addr == BUS_ADDR_LEN'(s)) begin
                rd_hit_s      = ~rd_empty_s[s];
                rd_sel_data_s = rd_dout_s[s];
            end else begin
                rd_hit_s = rd_hit_s;
            end
            if (bus.bus_src == BUS_ADDR_LEN'(s)) begin
                src_ok_s       = 1'b1;
                slot_blocked_s = rd_buffer_full[s] & ~rd_pop_req_s[s];
            end else begin
                src_ok_s = src_ok_s;
            end
        end
        drop_s = bus.bus_valid & (~src_ok_s | slot_blocked_s);
    end

    // Registered pop result, frozen while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_valid_r <= 1'b0;
            src_data_r  <= '0;
        end else if (!stall) begin
            src_valid_r <= src_rq & rd_hit_s;
            if (src_rq && rd_hit_s) src_data_r <= rd_sel_data_s;
            else                    src_data_r <= src_data_r;
        end else begin
            src_valid_r <= src_valid_r;
        end
    end

    assign src_valid = src_valid_r;
    assign src_data  = src_data_r;

`ifdef SLV_OVERFLOW_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    // Saturating count of dropped incoming bus words.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt_r <= '0;
        end else if (drop_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_count = drop_cnt_r;
`else
    logic drop_unused_s;
    assign drop_unused_s = drop_s;
`endif
endmodule

// File: tb/tb_bus_slave_ctrl_mc.sv
// Directed bench for bus_slave_ctrl_mc with a queue-based reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_bus_slave_ctrl_mc;
    localparam int A  = 3;
    localparam int D  = 16;
    localparam int N  = 2;
    localparam int WD = 8;
    localparam int NS = 8;
    localparam int RD = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           stall = 1'b0;
    logic [N-1:0]   wr_valid = '0;
    logic [N*A-1:0] wr_addr = '0;
    logic [N*D-1:0] wr_data = '0;
    logic [N-1:0]   wr_full;
    logic           src_rq = 1'b0;
    logic [A-1:0]   src_addr = '0;
    logic           src_valid;
    logic [D-1:0]   src_data;
    logic [NS-1:0]  rd_buffer_full;
    logic [15:0]    drop_count;

    bus_slave_ctrl_mc_if #(.BUS_ADDR_LEN(A), .DATA_LEN(D)) bus_if ();

    bus_slave_ctrl_mc #(
        .BUS_ADDR_LEN(A), .DATA_LEN(D), .PE_ID(6), .NUM_WR_CH(N),
        .WR_FIFO_DEPTH(WD), .NUM_SRC(NS), .RD_DEPTH(RD)
    ) dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
        .bus(bus_if.slave),
        .src_rq(src_rq), .src_addr(src_addr), .src_valid(src_valid), .src_data(src_data),
`ifdef SLV_OVERFLOW_CNT_EN
        .drop_count(drop_count),
`endif
        .rd_buffer_full(rd_buffer_full)
    );

`ifndef SLV_OVERFLOW_CNT_EN
    assign drop_count = 16'h0000;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues for each write channel and read slot.
    logic [A+D-1:0] wq [N][$];
    logic [D-1:0]   rq [NS][$];
    logic           m_valid;
    logic [A-1:0]   m_addr;
    logic [D-1:0]   m_data;
    int             m_ptr;
    logic           m_src_valid;
    logic [D-1:0]   m_src_data;
    int             m_drop;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < N; c++) wq[c].delete();
            for (int s = 0; s < NS; s++) rq[s].delete();
            m_valid = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0;
            m_src_valid = 1'b0; m_src_data = '0; m_drop = 0;
        end else begin
            bit found;
            logic [A+D-1:0] e;
            int c;
            for (int k = 0; k < N; k++)
                if (wr_valid[k] && wq[k].size() < WD)
                    wq[k].push_back({wr_addr[k*A +: A], wr_data[k*D +: D]});
            if (!m_valid || bus_if.bus_grant) begin
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    c = (m_ptr + i) % N;
                    if (!found && wq[c].size() > 0) begin
                        e = wq[c].pop_front();
                        m_addr = e[A+D-1:D]; m_data = e[D-1:0];
                        m_ptr = (c + 1) % N; found = 1'b1;
                    end
                end
                m_valid = found;
            end
            if (!stall) begin
                if (src_rq && int'(src_addr) < NS && rq[src_addr].size() > 0) begin
                    m_src_valid = 1'b1; m_src_data = rq[src_addr].pop_front();
                end else begin
                    m_src_valid = 1'b0;
                end
            end
            if (bus_if.bus_valid) begin
                if (int'(bus_if.bus_src) < NS && rq[bus_if.bus_src].size() < RD)
                    rq[bus_if.bus_src].push_back(bus_if.bus_data);
                else if (m_drop < 65535)
                    m_drop++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    logic [D-1:0] granted_q [$];
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NS-1:0] exp_rdf;
            logic [N-1:0]  exp_wf;
            for (int s = 0; s < NS; s++) exp_rdf[s] = (rq[s].size() == RD);
            for (int c = 0; c < N; c++) exp_wf[c] = (wq[c].size() >= WD);
            check("valid_to_bus", 32'(bus_if.valid_to_bus), 32'(m_valid));
            if (m_valid) begin
                check("addr_to_bus", 32'(bus_if.addr_to_bus), 32'(m_addr));
                check("data_to_bus", 32'(bus_if.data_to_bus), 32'(m_data));
            end
            check("bus_src_out", 32'(bus_if.bus_src_out), 32'd6);
            check("src_valid", 32'(src_valid), 32'(m_src_valid));
            check("src_data", 32'(src_data), 32'(m_src_data));
            check("wr_full", 32'(wr_full), 32'(exp_wf));
            check("rd_buffer_full", 32'(rd_buffer_full), 32'(exp_rdf));
`ifdef SLV_OVERFLOW_CNT_EN
            check("drop_count", 32'(drop_count), 32'(m_drop));
`endif
            if (bus_if.valid_to_bus && bus_if.bus_grant) granted_q.push_back(bus_if.data_to_bus);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        wr_valid = '0; bus_if.bus_valid = 1'b0; src_rq = 1'b0; stall = 1'b0;
    endtask

    task automatic bus_push(input logic [A-1:0] src, input logic [D-1:0] data);
        bus_if.bus_valid = 1'b1; bus_if.bus_src = src; bus_if.bus_data = data;
    endtask

    task automatic pop_expect(input string name, input logic [A-1:0] slot, input logic v, input logic [D-1:0] data);
        src_rq = 1'b1; src_addr = slot;
        tick();
        src_rq = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 32'(src_valid), 32'(v));
        if (v) check({name, "_data"}, 32'(src_data), 32'(data));
    endtask

    initial begin
        bus_if.bus_grant = 1'b0; bus_if.bus_valid = 1'b0;
        bus_if.bus_src = '0; bus_if.bus_data = '0;
        chk_en = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
        @(negedge clk);
        check("reset_valid", 32'(bus_if.valid_to_bus), 32'd0);
        check("reset_src_valid", 32'(src_valid), 32'd0);

        // Two channels, three words each, grant held high.
        bus_if.bus_grant = 1'b1;
        granted_q.delete();
        for (int k = 0; k < 3; k++) begin
            wr_valid = 2'b11;
            wr_addr = {3'd2, 3'd1};
            wr_data = {16'h2000 + 16'(k), 16'h1000 + 16'(k)};
            tick();
        end
        idle();
        repeat (8) tick();
        check("rr_count", 32'(granted_q.size()), 32'd6);
        if (granted_q.size() == 6) begin
            check("rr_0", 32'(granted_q[0]), 32'h1000);
            check("rr_1", 32'(granted_q[1]), 32'h2000);
            check("rr_2", 32'(granted_q[2]), 32'h1001);
            check("rr_3", 32'(granted_q[3]), 32'h2001);
            check("rr_4", 32'(granted_q[4]), 32'h1002);
            check("rr_5", 32'(granted_q[5]), 32'h2002);
        end

        // Held word without grant stays stable.
        bus_if.bus_grant = 1'b0;
        wr_valid = 2'b10; wr_addr = {3'd5, 3'd0}; wr_data = {16'hA5A5, 16'h0000};
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus_if.valid_to_bus), 32'd1);
            check("hold_addr", 32'(bus_if.addr_to_bus), 32'd5);
            check("hold_data", 32'(bus_if.data_to_bus), 32'hA5A5);
            tick();
        end
        bus_if.bus_grant = 1'b1;
        tick();
        @(negedge clk);
        check("hold_release", 32'(bus_if.valid_to_bus), 32'd0);

        // Five words into slot 2 of depth 4: last one dropped.
        for (int k = 0; k < 5; k++) begin
            bus_push(3'd2, 16'h3000 + 16'(k));
            tick();
        end
        idle();
        @(negedge clk);
        check("slot2_full", 32'(rd_buffer_full[2]), 32'd1);
`ifdef SLV_OVERFLOW_CNT_EN
        check("drop_one", 32'(drop_count), 32'd1);
`endif
        for (int k = 0; k < 4; k++) pop_expect("slot2_pop", 3'd2, 1'b1, 16'h3000 + 16'(k));
        pop_expect("slot2_empty", 3'd2, 1'b0, 16'h0000);

        // Full slot 3 with concurrent push and pop.
        for (int k = 0; k < 4; k++) begin
            bus_push(3'd3, 16'h4000 + 16'(k));
            tick();
        end
        bus_push(3'd3, 16'h4FFF);
        src_rq = 1'b1; src_addr = 3'd3;
        tick();
        idle();
        @(negedge clk);
        check("pp_valid", 32'(src_valid), 32'd1);
        check("pp_data", 32'(src_data), 32'h4000);
        check("pp_still_full", 32'(rd_buffer_full[3]), 32'd1);
        for (int k = 1; k < 4; k++) pop_expect("pp_pop", 3'd3, 1'b1, 16'h4000 + 16'(k));
        pop_expect("pp_last", 3'd3, 1'b1, 16'h4FFF);

        // Stall freezes pops while bus pushes continue.
        stall = 1'b1; src_rq = 1'b1; src_addr = 3'd4;
        bus_push(3'd4, 16'h5555);
        tick();
        bus_if.bus_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(src_valid), 32'd1);
            check("stall_data", 32'(src_data), 32'h4FFF);
            if (k < 2) tick();
        end
        stall = 1'b0;
        tick();
        src_rq = 1'b0;
        @(negedge clk);
        check("unstall_valid", 32'(src_valid), 32'd1);
        check("unstall_data", 32'(src_data), 32'h5555);

        // Fill channel 0 past its depth without grant.
        bus_if.bus_grant = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wr_valid = 2'b01; wr_addr = {3'd0, 3'd7}; wr_data = {16'h0000, 16'h6000 + 16'(k)};
            tick();
        end
        idle();
        @(negedge clk);
        check("wr_full_ch0", 32'(wr_full), 32'd1);
        check("wr_full_head", 32'(bus_if.data_to_bus), 32'h6000);

        // Reset mid-transfer.
        #2 rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus_if.valid_to_bus), 32'd0);
        check("mid_rst_addr", 32'(bus_if.addr_to_bus), 32'd0);
        check("mid_rst_data", 32'(bus_if.data_to_bus), 32'd0);
        check("mid_rst_wr_full", 32'(wr_full), 32'd0);
        check("mid_rst_src_data", 32'(src_data), 32'd0);
        tick();
        rstn = 1'b1;
        bus_if.bus_grant = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("post_rst_empty", 32'(bus_if.valid_to_bus), 32'd0);
        pop_expect("post_rst_slot4", 3'd4, 1'b0, 16'h0000);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
